br_commit_tracker: RTL and testbench

Tracks every conditional branch predicted at fetch, collects out-of-order resolutions from the branch execution unit, and retires branches in program order. It drives the in-order commit/feedback signals (`br_commit_`, `br_taken_`, `br_pred_miss_`) consumed by the counter predictor's training port. It sits between fetch/branch-execute and the predictor, as the producer end of the train interface.

---
 rtl/br_commit_tracker_pkg.sv | 9 +
 rtl/br_commit_tracker_if.sv | 33 +++
 rtl/br_commit_tracker_retire_sel.sv | 32 +++
 rtl/br_commit_tracker.sv | 145 ++++++++++++++
 tb/tb_br_commit_tracker.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/br_commit_tracker_pkg.sv
// Sizing defaults for the in-order branch commit tracker.
// Modules and interfaces import this package for their parameter defaults.
package br_commit_tracker_pkg;

  localparam int unsigned SIM_BR_FETCH   = 2;
  localparam int unsigned SIM_BR_COMMIT  = 2;
  localparam int unsigned PRED_MAX_DEPTH = 8;

endpackage

// File: rtl/br_commit_tracker_if.sv
// Fetch/execute-facing bus of the branch commit tracker.
// The master side drives allocate and resolve; the slave side returns tags, busy and commit feedback.
interface br_commit_tracker_if
  import br_commit_tracker_pkg::*;
#(
  parameter int unsigned SIMBRF   = SIM_BR_FETCH,
  parameter int unsigned SIMBRCOM = SIM_BR_COMMIT,
  parameter int unsigned DEPTH    = PRED_MAX_DEPTH,
  parameter int unsigned TAG      = $clog2(DEPTH)
);

  logic [SIMBRF-1:0]     br_;
  logic [SIMBRF-1:0]     pred_taken;
  logic [SIMBRF*TAG-1:0] br_tag;
  logic                  busy;
  logic                  res_;
  logic [TAG-1:0]        res_tag;
  logic                  res_taken;
  logic [SIMBRCOM-1:0]   br_commit_;
  logic [SIMBRCOM-1:0]   br_taken_;
  logic [SIMBRCOM-1:0]   br_pred_miss_;

  modport master (
    output br_, pred_taken, res_, res_tag, res_taken,
    input  br_tag, busy, br_commit_, br_taken_, br_pred_miss_
  );

  modport slave (
    input  br_, pred_taken, res_, res_tag, res_taken,
    output br_tag, busy, br_commit_, br_taken_, br_pred_miss_
  );

endinterface

// File: rtl/br_commit_tracker_retire_sel.sv
// Retire selector: from the valid&resolved window starting at head, finds the
// contiguous retire count and the entry index feeding each commit lane.
module br_retire_sel
  import br_commit_tracker_pkg::*;
#(
  parameter int unsigned DEPTH    = PRED_MAX_DEPTH,
  parameter int unsigned SIMBRCOM = SIM_BR_COMMIT,
  parameter int unsigned TAG      = $clog2(DEPTH)
) (
  input  logic [TAG-1:0]          head,
  input  logic [SIMBRCOM-1:0]     vr_rot,
  output logic [TAG:0]            ret_n,
  output logic [SIMBRCOM*TAG-1:0] ret_idx
);

  localparam int unsigned CW = TAG + 1;

  logic run;

  // Counting stops at the first hole so lanes stay contiguous from lane 0.
  always_comb begin
    ret_n   = '0;
    ret_idx = '0;
    run     = 1'b1;
    for (int unsigned i = 0; i < SIMBRCOM; i++) begin
      run = run & vr_rot[i];
      if (run) ret_n = ret_n + CW'(1);
      ret_idx[i*TAG +: TAG] = head + TAG'(i);
    end
  end

endmodule

// File: rtl/br_commit_tracker.sv
// In-order branch commit tracker: allocates predicted branches, collects
// out-of-order resolutions and retires them in program order to the predictor.
module br_commit_tracker
  import br_commit_tracker_pkg::*;
#(
  parameter int unsigned SIMBRF   = SIM_BR_FETCH,
  parameter int unsigned SIMBRCOM = SIM_BR_COMMIT,
  parameter int unsigned DEPTH    = PRED_MAX_DEPTH,
  parameter int unsigned TAG      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_,
  br_commit_tracker_if.slave bus
);

  localparam int unsigned CW = TAG + 1;

  logic [DEPTH-1:0]        valid_q, valid_d, resolved_q, resolved_d;
  logic [DEPTH-1:0]        pred_q, pred_d, taken_q, taken_d;
  logic [TAG-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [SIMBRCOM-1:0]     commit_q, commit_d, taken_out_q, taken_out_d, miss_q, miss_d;

  logic [SIMBRCOM-1:0]     vr_rot;
  logic [CW-1:0]           ret_n, alloc_n;
  logic [SIMBRCOM*TAG-1:0] ret_idx;
  logic [SIMBRF*TAG-1:0]   lane_tag;
  logic                    busy, alloc_ok;

  assign busy     = count_q > CW'(DEPTH - SIMBRF);
  assign alloc_ok = flush_ && !busy;

  always_comb begin
    vr_rot = '0;
    for (int unsigned k = 0; k < SIMBRCOM; k++) begin
      vr_rot[k] = valid_q[head_q + TAG'(k)] & resolved_q[head_q + TAG'(k)];
    end
  end

  // Active lanes are packed: each lane's tag is tail plus the active lanes below it.
  always_comb begin
    alloc_n  = '0;
    lane_tag = '0;
    for (int unsigned l = 0; l < SIMBRF; l++) begin
      lane_tag[l*TAG +: TAG] = tail_q + alloc_n[TAG-1:0];
      if (!bus.br_[l]) alloc_n = alloc_n + CW'(1);
    end
  end

  br_retire_sel #(
    .DEPTH    (DEPTH),
    .SIMBRCOM (SIMBRCOM),
    .TAG      (TAG)
  ) u_retire_sel (
    .head    (head_q),
    .vr_rot  (vr_rot),
    .ret_n   (ret_n),
    .ret_idx (ret_idx)
  );

  always_comb begin
    valid_d     = valid_q;
    resolved_d  = resolved_q;
    pred_d      = pred_q;
    taken_d     = taken_q;
    head_d      = head_q + ret_n[TAG-1:0];
    tail_d      = tail_q;
    count_d     = count_q - ret_n;
    commit_d    = '1;
    taken_out_d = '1;
    miss_d      = '1;

    for (int unsigned i = 0; i < SIMBRCOM; i++) begin
      if (CW'(i) < ret_n) begin
        valid_d[ret_idx[i*TAG +: TAG]] = 1'b0;
        commit_d[i]    = 1'b0;
        taken_out_d[i] = ~taken_q[ret_idx[i*TAG +: TAG]];
        miss_d[i]      = ~(taken_q[ret_idx[i*TAG +: TAG]] ^ pred_q[ret_idx[i*TAG +: TAG]]);
      end
    end

    if (!bus.res_ && valid_q[bus.res_tag] && !resolved_q[bus.res_tag]) begin
      resolved_d[bus.res_tag] = 1'b1;
      taken_d[bus.res_tag]    = bus.res_taken;
    end

    // Not busy guarantees SIMBRF free slots, so allocation never lands on a retiring entry.
    if (alloc_ok) begin
      for (int unsigned l = 0; l < SIMBRF; l++) begin
        if (!bus.br_[l]) begin
          valid_d[lane_tag[l*TAG +: TAG]]    = 1'b1;
          resolved_d[lane_tag[l*TAG +: TAG]] = 1'b0;
          pred_d[lane_tag[l*TAG +: TAG]]     = bus.pred_taken[l];
        end
      end
      tail_d  = tail_q + alloc_n[TAG-1:0];
      count_d = count_d + alloc_n;
    end

    if (!flush_) begin
      valid_d     = '0;
      resolved_d  = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      commit_d    = '1;
      taken_out_d = '1;
      miss_d      = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      resolved_q  <= '0;
      pred_q      <= '0;
      taken_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      commit_q    <= '1;
      taken_out_q <= '1;
      miss_q      <= '1;
    end else begin
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      pred_q      <= pred_d;
      taken_q     <= taken_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      commit_q    <= commit_d;
      taken_out_q <= taken_out_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.br_tag        = lane_tag;
  assign bus.busy          = busy;
  assign bus.br_commit_    = commit_q;
  assign bus.br_taken_     = taken_out_q;
  assign bus.br_pred_miss_ = miss_q;

endmodule

// File: tb/tb_br_commit_tracker.sv
// Directed bench for br_commit_tracker (SIMBRF=2, SIMBRCOM=2, DEPTH=8).
// Output vectors are written {lane1, lane0}; all values are active-low.
module tb_br_commit_tracker;

  logic clk = 1'b0;
  logic rst;
  logic flush_;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  br_commit_tracker_if #(.SIMBRF(2), .SIMBRCOM(2), .DEPTH(8)) bif ();

  br_commit_tracker #(.SIMBRF(2), .SIMBRCOM(2), .DEPTH(8)) dut (
    .clk    (clk),
    .reset  (rst),
    .flush_ (flush_),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] c, input logic [1:0] t,
                           input logic [1:0] m);
    check_eq({tag, "_commit"}, bif.br_commit_, c);
    check_eq({tag, "_taken"}, bif.br_taken_, t);
    check_eq({tag, "_miss"}, bif.br_pred_miss_, m);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res_set(input logic [2:0] t, input logic tk);
    bif.res_      = 1'b0;
    bif.res_tag   = t;
    bif.res_taken = tk;
  endtask

  initial begin
    rst            = 1'b1;
    flush_         = 1'b1;
    bif.br_        = '1;
    bif.pred_taken = '0;
    bif.res_       = 1'b1;
    bif.res_tag    = '0;
    bif.res_taken  = 1'b0;

    // Reset, then idle
    #2;
    check_out("reset", 2'b11, 2'b11, 2'b11);
    check_eq("reset_busy", bif.busy, 0);
    #10 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_commit", bif.br_commit_, 2'b11);
    end

    // In-order: tags 0,1 with pred 1,0; both resolve taken (tag1 first so they retire together)
    bif.br_ = 2'b00; bif.pred_taken = 2'b01; #1;
    check_eq("io_tags", bif.br_tag, {3'd1, 3'd0});
    tick(); bif.br_ = '1;
    res_set(3'd1, 1'b1); tick();
    check_eq("io_wait1", bif.br_commit_, 2'b11);
    res_set(3'd0, 1'b1); tick();
    check_eq("io_wait2", bif.br_commit_, 2'b11);
    bif.res_ = 1'b1; tick();
    check_out("io_retire", 2'b00, 2'b00, 2'b01);
    tick();
    check_eq("io_pulse", bif.br_commit_, 2'b11);

    // Out-of-order: tags 2,3,4 (pred 0) resolved 4,3,2
    bif.br_ = 2'b00; bif.pred_taken = 2'b00; tick();
    bif.br_ = 2'b10; #1;
    check_eq("ooo_tag4", bif.br_tag[2:0], 3'd4);
    tick(); bif.br_ = '1;
    res_set(3'd4, 1'b1); tick();
    check_eq("ooo_wait4", bif.br_commit_, 2'b11);
    res_set(3'd3, 1'b0); tick();
    check_eq("ooo_wait3", bif.br_commit_, 2'b11);
    res_set(3'd2, 1'b1); tick();
    check_eq("ooo_wait2", bif.br_commit_, 2'b11);
    bif.res_ = 1'b1; tick();
    check_out("ooo_pair", 2'b00, 2'b10, 2'b10);
    tick();
    check_out("ooo_last", 2'b10, 2'b10, 2'b10);
    tick();
    check_eq("ooo_idle", bif.br_commit_, 2'b11);

    // Full and wrap
    flush_ = 1'b0; tick(); flush_ = 1'b1;
    check_eq("fw_flush", bif.br_commit_, 2'b11);
    bif.br_ = 2'b00; bif.pred_taken = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    check_eq("fw_six_busy", bif.busy, 0);
    tick();
    check_eq("fw_full_busy", bif.busy, 1);
    check_eq("fw_drop_tag_pre", bif.br_tag, {3'd1, 3'd0});
    tick();
    check_eq("fw_drop_tag", bif.br_tag, {3'd1, 3'd0});
    check_eq("fw_drop_busy", bif.busy, 1);
    bif.br_ = '1;
    res_set(3'd1, 1'b0); tick();
    res_set(3'd0, 1'b1); tick();
    bif.res_ = 1'b1; tick();
    check_out("fw_retire", 2'b00, 2'b10, 2'b10);
    check_eq("fw_free_busy", bif.busy, 0);
    bif.br_ = 2'b00; #1;
    check_eq("fw_wrap_tags", bif.br_tag, {3'd1, 3'd0});
    tick(); bif.br_ = '1;
    check_eq("fw_refull_busy", bif.busy, 1);

    // Flush with 5 valid, 2 resolved; same-cycle allocate/resolve discarded
    flush_ = 1'b0; tick(); flush_ = 1'b1;
    bif.br_ = 2'b00; tick(); tick();
    bif.br_ = 2'b10; tick(); bif.br_ = '1;
    res_set(3'd3, 1'b1); tick();
    res_set(3'd4, 1'b0); tick();
    flush_ = 1'b0; bif.br_ = 2'b00; res_set(3'd0, 1'b1); tick();
    flush_ = 1'b1; bif.br_ = '1; bif.res_ = 1'b1;
    check_eq("fl_no_commit", bif.br_commit_, 2'b11);
    check_eq("fl_busy", bif.busy, 0);
    bif.br_ = 2'b00; #1;
    check_eq("fl_tag0", bif.br_tag, {3'd1, 3'd0});
    tick(); tick(); tick();
    check_eq("fl_six_busy", bif.busy, 0);
    bif.br_ = 2'b10; tick(); bif.br_ = '1;
    check_eq("fl_seven_busy", bif.busy, 1);

    // Asynchronous reset between edges with commits pending (tags 0..6, pred 0)
    res_set(3'd1, 1'b1); tick();
    res_set(3'd0, 1'b0); tick();
    res_set(3'd2, 1'b1); tick();
    bif.res_ = 1'b1;
    check_out("ar_commit", 2'b00, 2'b01, 2'b01);
    #2 rst = 1'b1;
    #1;
    check_out("ar_async", 2'b11, 2'b11, 2'b11);
    check_eq("ar_busy", bif.busy, 0);
    #3 rst = 1'b0;
    res_set(3'd2, 1'b1); tick();
    bif.res_ = 1'b1; tick();
    check_eq("ar_stale1", bif.br_commit_, 2'b11);
    tick();
    check_eq("ar_stale2", bif.br_commit_, 2'b11);
    bif.br_ = 2'b00; #1;
    check_eq("ar_tag0", bif.br_tag, {3'd1, 3'd0});
    tick(); bif.br_ = '1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
